// File: rtl/alu_simd_pipe.sv
// -----------------------------------------------------------------------------
// alu_simd_pipe
//
// Pipelined SIMD adder/subtractor/logic unit. It has an optional input
// register stage (operands and controls captured together), a combinational
// ALU, and an optional output register stage. Every register honours CE and
// the synchronous active-low reset.
//
// Ports
//   CLK        clock; all state updates on the rising edge
//   RST_N      synchronous active-low reset; overrides CE
//   CE         clock enable for every pipeline register, including valid
//   IN_VALID   qualifies operands and controls this cycle
//   X_IN/Y_IN/Z_IN  N-bit operands
//   CIN        carry-in; used only in ONE mode (lane 0)
//   ALUMODE    operation select
//   OPMODE     only bits [3:2] are used (logic-mode select)
//   SIMD_MODE  00 = one lane, 01 = two lanes, 10 = four lanes, 11 = reserved
//   P          result
//   CARRYOUT   per-lane carry, mapped onto bit positions by lane count
//   OUT_VALID  P/CARRYOUT/ILLEGAL carry a real result
//   ILLEGAL    result came from a reserved ALUMODE/OPMODE/SIMD_MODE code
// -----------------------------------------------------------------------------
module alu_simd_pipe #(
   parameter int N     = 48,
   parameter int INREG = 1,
   parameter int PREG  = 1
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         CE,
   input  logic         IN_VALID,
   input  logic [N-1:0] X_IN,
   input  logic [N-1:0] Y_IN,
   input  logic [N-1:0] Z_IN,
   input  logic         CIN,
   input  logic [3:0]   ALUMODE,
   input  logic [6:0]   OPMODE,
   input  logic [1:0]   SIMD_MODE,
   output logic [N-1:0] P,
   output logic [3:0]   CARRYOUT,
   output logic         OUT_VALID,
   output logic         ILLEGAL
);

   // Only the logic-mode select field of OPMODE matters.
   logic unused_opmode;
   assign unused_opmode = ^{OPMODE[6:4], OPMODE[1:0]};

   // Stage-A view: either the input registers or the raw inputs.
   logic         a_valid;
   logic [N-1:0] a_x, a_y, a_z;
   logic         a_cin;
   logic [3:0]   a_alumode;
   logic [1:0]   a_lsel;
   logic [1:0]   a_simd;

   generate
      if (INREG != 0) begin : g_inreg
         logic         valid_q, valid_d;
         logic [N-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
         logic         cin_q, cin_d;
         logic [3:0]   alumode_q, alumode_d;
         logic [1:0]   lsel_q, lsel_d;
         logic [1:0]   simd_q, simd_d;

         always_comb begin
            valid_d   = valid_q;
            x_d       = x_q;
            y_d       = y_q;
            z_d       = z_q;
            cin_d     = cin_q;
            alumode_d = alumode_q;
            lsel_d    = lsel_q;
            simd_d    = simd_q;
            if (CE) begin
               valid_d   = IN_VALID;
               x_d       = X_IN;
               y_d       = Y_IN;
               z_d       = Z_IN;
               cin_d     = CIN;
               alumode_d = ALUMODE;
               lsel_d    = OPMODE[3:2];
               simd_d    = SIMD_MODE;
            end
         end

         always_ff @(posedge CLK) begin
            if (!RST_N) begin
               valid_q   <= 1'b0;
               x_q       <= '0;
               y_q       <= '0;
               z_q       <= '0;
               cin_q     <= 1'b0;
               alumode_q <= '0;
               lsel_q    <= '0;
               simd_q    <= '0;
            end else begin
               valid_q   <= valid_d;
               x_q       <= x_d;
               y_q       <= y_d;
               z_q       <= z_d;
               cin_q     <= cin_d;
               alumode_q <= alumode_d;
               lsel_q    <= lsel_d;
               simd_q    <= simd_d;
            end
         end

         assign a_valid   = valid_q;
         assign a_x       = x_q;
         assign a_y       = y_q;
         assign a_z       = z_q;
         assign a_cin     = cin_q;
         assign a_alumode = alumode_q;
         assign a_lsel    = lsel_q;
         assign a_simd    = simd_q;
      end else begin : g_inbyp
         assign a_valid   = IN_VALID;
         assign a_x       = X_IN;
         assign a_y       = Y_IN;
         assign a_z       = Z_IN;
         assign a_cin     = CIN;
         assign a_alumode = ALUMODE;
         assign a_lsel    = OPMODE[3:2];
         assign a_simd    = SIMD_MODE;
      end
   endgenerate

   // Arithmetic results for all three lane splits are built in parallel and
   // the SIMD mode picks one. Index 0 = one lane, 1 = two, 2 = four.
   logic [2:0][N-1:0] arith_p;
   logic [2:0][3:0]   arith_c;

   generate
      for (genvar mi = 0; mi < 3; mi++) begin : g_mode
         localparam int NL    = 1 << mi;
         localparam int L     = N / NL;
         localparam int CSTEP = 4 / NL;   // carry of lane k lands on bit (k+1)*CSTEP-1

         for (genvar gi = 0; gi < NL; gi++) begin : g_lane
            logic [L-1:0] x_l, y_l, z_l, zm_l, p_l, diff_l;
            logic [L+1:0] sum_l, xyc_l;
            logic         cin_l, c_l;
            logic         unused_sum_hi;

            always_comb begin
               x_l    = a_x[gi*L +: L];
               y_l    = a_y[gi*L +: L];
               z_l    = a_z[gi*L +: L];
               // Carry-in only reaches the single full-width lane.
               cin_l  = (mi == 0) ? a_cin : 1'b0;
               zm_l   = (a_alumode[1:0] == 2'b01) ? ~z_l : z_l;
               sum_l  = {2'b00, zm_l} + {2'b00, x_l} + {2'b00, y_l} + {{(L+1){1'b0}}, cin_l};
               xyc_l  = {2'b00, x_l} + {2'b00, y_l} + {{(L+1){1'b0}}, cin_l};
               diff_l = z_l - xyc_l[L-1:0];
               p_l    = sum_l[L-1:0];
               c_l    = sum_l[L];
               case (a_alumode[1:0])
                  2'b10: p_l = ~sum_l[L-1:0];
                  2'b11: begin
                     p_l = diff_l;
                     // "no borrow" is judged against the full-precision sum
                     c_l = ({2'b00, z_l} >= xyc_l);
                  end
                  default: ;
               endcase
            end

            assign unused_sum_hi                 = sum_l[L+1];
            assign arith_p[mi][gi*L +: L]        = p_l;
            assign arith_c[mi][(gi+1)*CSTEP-1]   = c_l;
         end

         // CARRYOUT positions that no lane owns in this split stay 0.
         for (genvar bi = 0; bi < 4; bi++) begin : g_czero
            if (((bi + 1) % CSTEP) != 0) begin : g_z
               assign arith_c[mi][bi] = 1'b0;
            end
         end
      end
   endgenerate

   // Bitwise modes between X and Z, always full width.
   logic [N-1:0] logic_p;

   always_comb begin
      logic_p = '0;
      case (a_alumode)
         4'b0100, 4'b0111: logic_p = a_lsel[1] ? ~(a_x ^ a_z) :  (a_x ^ a_z);
         4'b0101, 4'b0110: logic_p = a_lsel[1] ?  (a_x ^ a_z) : ~(a_x ^ a_z);
         4'b1100:          logic_p = a_lsel[1] ?  (a_x | a_z) :  (a_x & a_z);
         4'b1101:          logic_p = a_lsel[1] ?  (a_x | ~a_z) : (a_x & ~a_z);
         4'b1110:          logic_p = a_lsel[1] ? ~(a_x | a_z) : ~(a_x & a_z);
         4'b1111:          logic_p = a_lsel[1] ? (~a_x & a_z) : (~a_x | a_z);
         default:          logic_p = '0;
      endcase
   end

   logic         is_logic, res_ill;
   logic [N-1:0] res_p;
   logic [3:0]   res_c;

   always_comb begin
      // ALUMODE x1xx selects the bitwise group; 10xx is reserved.
      is_logic = a_alumode[2];
      res_ill  = (a_simd == 2'b11) || (a_alumode[3:2] == 2'b10) || (is_logic && a_lsel[0]);
      res_p    = '0;
      res_c    = '0;
      if (!res_ill) begin
         if (is_logic) begin
            res_p = logic_p;
         end else begin
            case (a_simd)
               2'b01:   begin res_p = arith_p[1]; res_c = arith_c[1]; end
               2'b10:   begin res_p = arith_p[2]; res_c = arith_c[2]; end
               default: begin res_p = arith_p[0]; res_c = arith_c[0]; end
            endcase
         end
      end
   end

   generate
      if (PREG != 0) begin : g_preg
         logic         valid_q, valid_d;
         logic [N-1:0] p_q, p_d;
         logic [3:0]   carry_q, carry_d;
         logic         illegal_q, illegal_d;

         always_comb begin
            valid_d   = valid_q;
            p_d       = p_q;
            carry_d   = carry_q;
            illegal_d = illegal_q;
            if (CE) begin
               valid_d   = a_valid;
               p_d       = res_p;
               carry_d   = res_c;
               illegal_d = res_ill;
            end
         end

         always_ff @(posedge CLK) begin
            if (!RST_N) begin
               valid_q   <= 1'b0;
               p_q       <= '0;
               carry_q   <= '0;
               illegal_q <= 1'b0;
            end else begin
               valid_q   <= valid_d;
               p_q       <= p_d;
               carry_q   <= carry_d;
               illegal_q <= illegal_d;
            end
         end

         assign OUT_VALID = valid_q;
         assign P         = p_q;
         assign CARRYOUT  = carry_q;
         assign ILLEGAL   = illegal_q;
      end else begin : g_pbyp
         assign OUT_VALID = a_valid;
         assign P         = res_p;
         assign CARRYOUT  = res_c;
         assign ILLEGAL   = res_ill;
      end
   endgenerate

endmodule

// File: tb/tb_alu_simd_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_simd_pipe
//
// Directed bench for alu_simd_pipe (N=48, INREG=PREG=1). A lane-level
// arithmetic model predicts each result, a queue tracks when each accepted
// transaction must be on the outputs (counted in CE cycles), and a negedge
// process compares every cycle. Hand-computed literal vectors pin both the
// DUT and the model.
// -----------------------------------------------------------------------------
module tb_alu_simd_pipe;
   localparam int N = 48;

   logic         CLK = 1'b0;
   logic         RST_N, CE, IN_VALID, CIN;
   logic [N-1:0] X_IN, Y_IN, Z_IN;
   logic [3:0]   ALUMODE;
   logic [6:0]   OPMODE;
   logic [1:0]   SIMD_MODE;
   logic [N-1:0] P;
   logic [3:0]   CARRYOUT;
   logic         OUT_VALID, ILLEGAL;

   always #5 CLK = ~CLK;

   alu_simd_pipe #(.N(N), .INREG(1), .PREG(1)) dut (
      .CLK(CLK), .RST_N(RST_N), .CE(CE), .IN_VALID(IN_VALID),
      .X_IN(X_IN), .Y_IN(Y_IN), .Z_IN(Z_IN), .CIN(CIN),
      .ALUMODE(ALUMODE), .OPMODE(OPMODE), .SIMD_MODE(SIMD_MODE),
      .P(P), .CARRYOUT(CARRYOUT), .OUT_VALID(OUT_VALID), .ILLEGAL(ILLEGAL)
   );

   typedef struct packed {
      logic         ill;
      logic [3:0]   c;
      logic [N-1:0] p;
   } res_t;

   typedef struct {
      res_t r;
      int   due;
   } exp_t;

   typedef struct packed {
      logic [1:0]   simd;
      logic [3:0]   alu;
      logic [1:0]   lsel;
      logic         cin;
      logic [N-1:0] x;
      logic [N-1:0] y;
      logic [N-1:0] z;
      logic         ill;
      logic [3:0]   c;
      logic [N-1:0] p;
   } lit_t;

   exp_t exp_q[$];
   int   ce_cycles = 0;
   int   n_done    = 0;
   int   n_vec     = 0;
   int   n_err     = 0;
   bit   chk_en    = 1'b0;
   lit_t lits[19];

   // Result of one operation straight from the operation table.
   function automatic res_t model(input logic [1:0] simd, input logic [3:0] alu,
                                  input logic [1:0] lsel, input logic cin,
                                  input logic [N-1:0] x, input logic [N-1:0] y,
                                  input logic [N-1:0] z);
      res_t r;
      int nl, lw, cpos;
      longint unsigned mask, xl, yl, zl, cl, s;
      r = '0;
      if (simd == 2'b11 || alu[3:2] == 2'b10 || (alu[2] && lsel[0])) begin
         r.ill = 1'b1;
         return r;
      end
      if (alu[2]) begin
         case (alu)
            4'b0100, 4'b0111: r.p = (lsel == 2'b00) ? (x ^ z) : ~(x ^ z);
            4'b0101, 4'b0110: r.p = (lsel == 2'b00) ? ~(x ^ z) : (x ^ z);
            4'b1100:          r.p = (lsel == 2'b00) ? (x & z) : (x | z);
            4'b1101:          r.p = (lsel == 2'b00) ? (x & ~z) : (x | ~z);
            4'b1110:          r.p = (lsel == 2'b00) ? ~(x & z) : ~(x | z);
            default:          r.p = (lsel == 2'b00) ? (~x | z) : (~x & z);
         endcase
         return r;
      end
      nl   = 1 << simd;
      lw   = N / nl;
      mask = (64'd1 << lw) - 64'd1;
      for (int k = 0; k < nl; k++) begin
         xl   = (64'(x) >> (k * lw)) & mask;
         yl   = (64'(y) >> (k * lw)) & mask;
         zl   = (64'(z) >> (k * lw)) & mask;
         cl   = (nl == 1) ? 64'(cin) : 64'd0;
         cpos = (4 / nl) * (k + 1) - 1;
         if (alu == 4'b0011) begin
            s = xl + yl + cl;
            r.p = r.p | N'(((zl - s) & mask) << (k * lw));
            r.c[cpos] = (zl >= s);
         end else begin
            if (alu == 4'b0001) zl = ~zl & mask;
            s = zl + xl + yl + cl;
            if (alu == 4'b0010) r.p = r.p | N'((~s & mask) << (k * lw));
            else                r.p = r.p | N'((s & mask) << (k * lw));
            r.c[cpos] = ((s >> lw) & 64'd1) != 64'd0;
         end
      end
      return r;
   endfunction

   // Accepted transactions become visible after the second CE edge and leave
   // at the following CE edge; reset discards everything in flight.
   always @(posedge CLK) begin
      if (RST_N !== 1'b1) begin
         exp_q.delete();
      end else if (CE === 1'b1) begin
         if (exp_q.size() > 0 && exp_q[0].due == ce_cycles) begin
            void'(exp_q.pop_front());
            n_done++;
         end
         ce_cycles++;
         if (IN_VALID === 1'b1) begin
            exp_t e;
            e.r   = model(SIMD_MODE, ALUMODE, OPMODE[3:2], CIN, X_IN, Y_IN, Z_IN);
            e.due = ce_cycles + 1;
            exp_q.push_back(e);
         end
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         logic exp_v;
         exp_v = (exp_q.size() > 0) && (exp_q[0].due == ce_cycles);
         n_vec++;
         if (OUT_VALID !== exp_v) begin
            n_err++;
            $display("FAIL out_valid @%0t: got %b want %b", $time, OUT_VALID, exp_v);
         end
         if (exp_v) begin
            n_vec++;
            if ({ILLEGAL, CARRYOUT, P} !== exp_q[0].r) begin
               n_err++;
               $display("FAIL result @%0t: got ill=%b co=%b p=%h want ill=%b co=%b p=%h",
                        $time, ILLEGAL, CARRYOUT, P, exp_q[0].r.ill, exp_q[0].r.c, exp_q[0].r.p);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, got, want);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] simd, input logic [3:0] alu,
                        input logic [1:0] lsel, input logic cin, input logic [N-1:0] x,
                        input logic [N-1:0] y, input logic [N-1:0] z);
      IN_VALID  = v;
      SIMD_MODE = simd;
      ALUMODE   = alu;
      // Unused OPMODE bits set non-zero so they are seen to be ignored.
      OPMODE    = {3'b101, lsel, 2'b11};
      CIN       = cin;
      X_IN      = x;
      Y_IN      = y;
      Z_IN      = z;
   endtask

   initial begin
      lit_t t;
      logic [63:0] held;
      int base;

      //              simd   alu      lsel   cin   x                y             z                ill   c        p
      lits[0]  = '{2'b00, 4'b0000, 2'b00, 1'b0, 48'h000000000001, 48'h2, 48'hFFFFFFFFFFFF, 1'b0, 4'b1000, 48'h000000000002};
      lits[1]  = '{2'b10, 4'b0000, 2'b00, 1'b1, 48'h001001001001, 48'h0, 48'hFFFFFFFFFFFF, 1'b0, 4'b1111, 48'h000000000000};
      lits[2]  = '{2'b01, 4'b0011, 2'b00, 1'b0, 48'h000007000003, 48'h0, 48'h000005000010, 1'b0, 4'b0010, 48'hFFFFFE00000D};
      lits[3]  = '{2'b00, 4'b1100, 2'b10, 1'b0, 48'h00FF00FF00FF, 48'h0, 48'h0F0F0F0F0F0F, 1'b0, 4'b0000, 48'h0FFF0FFF0FFF};
      lits[4]  = '{2'b00, 4'b1100, 2'b01, 1'b0, 48'h00FF00FF00FF, 48'h0, 48'h0F0F0F0F0F0F, 1'b1, 4'b0000, 48'h000000000000};
      lits[5]  = '{2'b01, 4'b0000, 2'b00, 1'b1, 48'h000000000001, 48'h0, 48'h000001FFFFFF, 1'b0, 4'b0010, 48'h000001000000};
      lits[6]  = '{2'b00, 4'b0001, 2'b00, 1'b1, 48'h000000000005, 48'h0, 48'h000000000000, 1'b0, 4'b1000, 48'h000000000005};
      lits[7]  = '{2'b00, 4'b0010, 2'b00, 1'b0, 48'h000000000001, 48'h1, 48'h000000000001, 1'b0, 4'b0000, 48'hFFFFFFFFFFFC};
      lits[8]  = '{2'b00, 4'b0011, 2'b00, 1'b1, 48'h000000000003, 48'h4, 48'h00000000000A, 1'b0, 4'b1000, 48'h000000000002};
      lits[9]  = '{2'b00, 4'b0011, 2'b00, 1'b0, 48'h000000000005, 48'h0, 48'h000000000005, 1'b0, 4'b1000, 48'h000000000000};
      lits[10] = '{2'b10, 4'b0011, 2'b00, 1'b1, 48'h001001001001, 48'h0, 48'h000000000000, 1'b0, 4'b0000, 48'hFFFFFFFFFFFF};
      lits[11] = '{2'b11, 4'b0000, 2'b00, 1'b0, 48'h000000000001, 48'h0, 48'h000000000001, 1'b1, 4'b0000, 48'h000000000000};
      lits[12] = '{2'b00, 4'b1000, 2'b00, 1'b0, 48'h000000000001, 48'h0, 48'h000000000001, 1'b1, 4'b0000, 48'h000000000000};
      lits[13] = '{2'b00, 4'b0100, 2'b00, 1'b0, 48'h00FF00FF00FF, 48'h0, 48'h0F0F0F0F0F0F, 1'b0, 4'b0000, 48'h0FF00FF00FF0};
      lits[14] = '{2'b01, 4'b0110, 2'b00, 1'b0, 48'h00FF00FF00FF, 48'h0, 48'h0F0F0F0F0F0F, 1'b0, 4'b0000, 48'hF00FF00FF00F};
      lits[15] = '{2'b10, 4'b1110, 2'b10, 1'b0, 48'h00FF00FF00FF, 48'h0, 48'h0F0F0F0F0F0F, 1'b0, 4'b0000, 48'hF000F000F000};
      lits[16] = '{2'b00, 4'b1111, 2'b00, 1'b0, 48'h00FF00FF00FF, 48'h0, 48'h0F0F0F0F0F0F, 1'b0, 4'b0000, 48'hFF0FFF0FFF0F};
      lits[17] = '{2'b00, 4'b1101, 2'b10, 1'b0, 48'h00FF00FF00FF, 48'h0, 48'h0F0F0F0F0F0F, 1'b0, 4'b0000, 48'hF0FFF0FFF0FF};
      lits[18] = '{2'b00, 4'b1100, 2'b00, 1'b0, 48'h00FF00FF00FF, 48'h0, 48'h0F0F0F0F0F0F, 1'b0, 4'b0000, 48'h000F000F000F};

      // Reset with CE low must still clear every register.
      RST_N = 1'b0;
      CE    = 1'b0;
      drive(1'b1, 2'b00, 4'b0000, 2'b00, 1'b0, '0, '0, '0);
      repeat (2) @(negedge CLK);
      chk("reset_out_valid", 64'(OUT_VALID), 64'd0);
      chk("reset_p",         64'(P),         64'd0);
      chk("reset_carryout",  64'(CARRYOUT),  64'd0);
      chk("reset_illegal",   64'(ILLEGAL),   64'd0);
      drive(1'b0, 2'b00, 4'b0000, 2'b00, 1'b0, '0, '0, '0);
      RST_N  = 1'b1;
      CE     = 1'b1;
      chk_en = 1'b1;
      @(negedge CLK);

      // Hand-computed vectors, one at a time.
      for (int i = 0; i < 19; i++) begin
         t = lits[i];
         drive(1'b1, t.simd, t.alu, t.lsel, t.cin, t.x, t.y, t.z);
         @(negedge CLK);
         IN_VALID = 1'b0;
         @(negedge CLK);
         chk($sformatf("lit%0d_valid", i), 64'(OUT_VALID), 64'd1);
         chk($sformatf("lit%0d_dut", i), 64'({ILLEGAL, CARRYOUT, P}), 64'({t.ill, t.c, t.p}));
         chk($sformatf("lit%0d_model", i),
             64'(model(t.simd, t.alu, t.lsel, t.cin, t.x, t.y, t.z)), 64'({t.ill, t.c, t.p}));
         $display("lit %0d: simd=%b alu=%b -> P=%h CO=%b ILL=%b", i, t.simd, t.alu, P, CARRYOUT, ILLEGAL);
      end
      repeat (2) @(negedge CLK);

      // Six back-to-back additions with a three-cycle CE stall mid-stream.
      base = n_done;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 2'(i % 3), 4'b0000, 2'b00, 1'(i & 1),
               48'h0123456789AB * (i + 1), 48'hFFFF00001111 >> i, 48'h800800800FFF);
         if (i == 3) begin
            CE = 1'b0;
            @(negedge CLK);
            held = 64'({OUT_VALID, ILLEGAL, CARRYOUT, P});
            repeat (2) begin
               @(negedge CLK);
               chk("stall_hold", 64'({OUT_VALID, ILLEGAL, CARRYOUT, P}), held);
            end
            CE = 1'b1;
         end
         @(negedge CLK);
         $display("stream %0d: P=%h CO=%b OUT_VALID=%b", i, P, CARRYOUT, OUT_VALID);
      end
      IN_VALID = 1'b0;
      repeat (3) @(negedge CLK);
      chk("stream_count", 64'(n_done - base), 64'd6);

      // Reset with CE low and two transactions in flight.
      drive(1'b1, 2'b00, 4'b0000, 2'b00, 1'b0, 48'h111, 48'h222, 48'h333);
      @(negedge CLK);
      drive(1'b1, 2'b10, 4'b0000, 2'b00, 1'b0, 48'h444, 48'h555, 48'h666);
      @(negedge CLK);
      IN_VALID = 1'b0;
      CE       = 1'b0;
      RST_N    = 1'b0;
      @(negedge CLK);
      RST_N = 1'b1;
      chk("rst_flight_valid", 64'(OUT_VALID), 64'd0);
      chk("rst_flight_p",     64'(P),         64'd0);
      CE = 1'b1;
      repeat (4) begin
         @(negedge CLK);
         chk("no_stale", 64'(OUT_VALID), 64'd0);
      end

      // Mixed sweep over all codes with random CE gaps, checked by the model.
      for (int i = 0; i < 120; i++) begin
         drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               {16'($urandom), $urandom}, {16'($urandom), $urandom}, {16'($urandom), $urandom});
         CE = ($urandom_range(0, 5) != 0);
         @(negedge CLK);
      end
      IN_VALID = 1'b0;
      CE       = 1'b1;
      repeat (3) @(negedge CLK);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_simd_pipe.md
ALU_SIMD_PIPE -- requirements
Module: alu_simd_pipe

Interface
REQ-001 The block SHALL have these parameters, one per line:
- N, 48, datapath width; multiple of 4, >= 8
- INREG, 1, input register stage present (1) or bypassed (0)
- PREG, 1, output register stage present (1) or bypassed (0)
REQ-002 The block SHALL have these ports, one per line:
- CLK  in  1  single clock; all state updates on rising edge
- RST_N  in  1  synchronous, active-low reset
- CE  in  1  clock enable for every pipeline register
- IN_VALID  in  1  qualifies X_IN/Y_IN/Z_IN/CIN/control this cycle
- X_IN, Y_IN, Z_IN  in  N each  operands, two's complement
- CIN  in  1  carry-in
- ALUMODE  in  4  operation select
- OPMODE  in  7  only OPMODE[3:2] used (logic-mode select)
- SIMD_MODE  in  2  00 = ONE (lane L=N), 01 = TWO (L=N/2), 10 = FOUR (L=N/4), 11 = reserved
- P  out  N  result
- CARRYOUT  out  4  per-lane carry
- OUT_VALID  out  1  P/CARRYOUT/ILLEGAL valid
- ILLEGAL  out  1  reserved ALUMODE/OPMODE/SIMD_MODE code in this result
REQ-003 One clock domain SHALL be used; RST_N SHALL be synchronous and active-low.

Function
REQ-004 Control inputs SHALL be captured in the same register stage as their operands, so every result uses the controls presented with its operands.
REQ-005 Latency IN_VALID -> OUT_VALID SHALL be INREG+PREG cycles of CE=1; with INREG=PREG=0 the path SHALL be combinational.
REQ-006 CE=0 SHALL hold every register, including the valid pipeline; no transaction is lost or duplicated.
REQ-007 Operands SHALL be split into N/L independent lanes; lane k = bits [k*L+L-1 : k*L]; carries SHALL NOT cross lane boundaries.
REQ-008 CIN SHALL feed lane 0 only in ONE mode; in TWO and FOUR, cin = 0 for all lanes.
REQ-009 Per lane, S = Zm + X + Y + cin computed at L+2 bits unsigned:
- ALUMODE 0000: Zm = Z; P = S[L-1:0]; carry = S[L]
- 0001: Zm = ~Z; P = S[L-1:0]; carry = S[L]
- 0010: Zm = Z; P = ~S[L-1:0]; carry = S[L]
- 0011: P = (Z - (X+Y+cin)) mod 2^L; carry = 1 iff Z >= X+Y+cin (unsigned, L+2-bit sum)
REQ-010 Logic modes SHALL act on the full width regardless of SIMD_MODE, with CARRYOUT = 0:
- 0100/0111: XOR if OPMODE[3:2]=00, XNOR if 10
- 0101/0110: XNOR if 00, XOR if 10
- 1100: AND if 00, OR if 10
- 1101: X&~Z if 00, X|~Z if 10
- 1110: NAND if 00, NOR if 10
- 1111: ~X|Z if 00, ~X&Z if 10
REQ-011 A logic mode with OPMODE[3:2] in {01,11}, ALUMODE in {1000..1011}, or SIMD_MODE=11 SHALL give P=0, CARRYOUT=0, ILLEGAL=1; otherwise ILLEGAL=0.
REQ-012 CARRYOUT mapping SHALL be: FOUR: bit k = lane k; TWO: bit1 = lane 0, bit3 = lane 1, bits 0 and 2 = 0; ONE: bit3 = carry, bits 2:0 = 0.
REQ-013 When OUT_VALID=0, P/CARRYOUT/ILLEGAL SHALL still follow pipeline contents; checkers SHALL ignore them.
REQ-014 Back-to-back IN_VALID at full rate SHALL yield one result per CE cycle, in order.

Reset
REQ-015 With RST_N=0 at a rising edge, every register SHALL clear (P=0, CARRYOUT=0, OUT_VALID=0, ILLEGAL=0), independent of CE.
REQ-016 Reset SHALL override CE and IN_VALID; in-flight transactions are discarded; the first input accepted after release appears INREG+PREG cycles later.

Verification
REQ-017 ONE, ALUMODE=0000, Z=0xFFFFFFFFFFFF, X=1, Y=2, CIN=0 -> two cycles later P=0x000000000002, CARRYOUT=1000, OUT_VALID=1.
REQ-018 FOUR, ALUMODE=0000, Z=0xFFFFFFFFFFFF, X=0x001001001001, Y=0, CIN=1 -> P=0x000000000000, CARRYOUT=1111 (CIN ignored).
REQ-019 TWO, ALUMODE=0011, Z=0x000005000010, X=0x000007000003, Y=0 -> P=0xFFFFFE00000D, CARRYOUT=0010.
REQ-020 ALUMODE=1100 with OPMODE[3:2]=10, X=0x00FF00FF00FF, Z=0x0F0F0F0F0F0F -> P=0x0FFF0FFF0FFF, ILLEGAL=0; same operands with OPMODE[3:2]=01 -> P=0, ILLEGAL=1.
REQ-021 Stream of 6 additions with CE=0 for 3 cycles mid-stream -> 6 results in order, outputs frozen during the stall, no duplicates.
REQ-022 RST_N=0 for one cycle with CE=0 and 2 transactions in flight -> next cycle OUT_VALID=0, P=0, and no stale result ever appears.
